// File: rtl/bandit_environment_if.sv
// Bandit environment bus: groups the action stream (agent -> environment),
// the reward stream (environment -> agent), the probability write port and
// the pull counter.
//   master : agent / configuration side
//   slave  : environment side (bandit_environment)
interface bandit_environment_if #(
  parameter int ACTION_WIDTH = 8,
  parameter int REWARD_WIDTH = 16
);
  logic                           action_valid;
  logic [ACTION_WIDTH-1:0]        action_data;
  logic                           action_ready;
  logic                           reward_valid;
  logic signed [REWARD_WIDTH-1:0] reward_data;
  logic                           reward_ready;
  logic                           cfg_valid;
  logic [ACTION_WIDTH-1:0]        cfg_index;
  logic [7:0]                     cfg_prob;
  logic                           cfg_ready;
  logic [31:0]                    pull_count;

  modport master (
    output action_valid, action_data, reward_ready,
    output cfg_valid, cfg_index, cfg_prob,
    input  action_ready, reward_valid, reward_data, cfg_ready, pull_count
  );

  modport slave (
    input  action_valid, action_data, reward_ready,
    input  cfg_valid, cfg_index, cfg_prob,
    output action_ready, reward_valid, reward_data, cfg_ready, pull_count
  );
endinterface

// File: rtl/bandit_environment.sv
// Bandit environment: accepts one arm index per transaction, looks up that
// arm's win threshold in a programmable table, draws against a free-running
// 16-bit Galois LFSR and returns REWARD_HIGH or REWARD_LOW.
//   clock   : rising-edge clock
//   reset_n : synchronous reset, active-low
//   bus     : bandit_environment_if.slave (action, reward, cfg, pull_count)
//
// state  | meaning
// CLEAR  | load INIT_PROB into every table entry, one per cycle
// IDLE   | ready for an action
// LOOKUP | registered table read of the latched arm
// DRAW   | compare LFSR low byte with threshold, latch reward
// RESP   | hold reward until the agent takes it
module bandit_environment #(
  parameter int ACTION_WIDTH = 8,
  parameter int REWARD_WIDTH = 16,
  parameter logic signed [REWARD_WIDTH-1:0] REWARD_HIGH = 16'sd256,
  parameter logic signed [REWARD_WIDTH-1:0] REWARD_LOW  = 16'sd0,
  parameter logic [7:0]  INIT_PROB = 8'd128,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clock,
  input logic reset_n,
  bandit_environment_if.slave bus
);

  localparam int ARMS = 2 ** ACTION_WIDTH;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_LOOKUP,
    S_DRAW,
    S_RESP
  } state_t;

  state_t                         state_q, state_d;
  logic [ACTION_WIDTH-1:0]        clr_idx_q, clr_idx_d;
  logic [ACTION_WIDTH-1:0]        arm_q, arm_d;
  logic [7:0]                     prob_q, prob_d;
  logic [15:0]                    lfsr_q, lfsr_d;
  logic                           action_ready_q, action_ready_d;
  logic                           cfg_ready_q, cfg_ready_d;
  logic                           reward_valid_q, reward_valid_d;
  logic signed [REWARD_WIDTH-1:0] reward_data_q, reward_data_d;
  logic [31:0]                    pull_count_q, pull_count_d;

  // Probability table: no reset, CLEAR is its only initialisation.
  logic [7:0]              prob_table [ARMS];
  logic                    tbl_we;
  logic [ACTION_WIDTH-1:0] tbl_waddr;
  logic [7:0]              tbl_wdata;
  logic                    win;

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = bus.cfg_index;
    tbl_wdata = bus.cfg_prob;
    if (state_q == S_CLEAR) begin
      tbl_we    = reset_n;
      tbl_waddr = clr_idx_q;
      tbl_wdata = INIT_PROB;
    end else begin
      tbl_we = reset_n & bus.cfg_valid & cfg_ready_q;
    end
  end

  always_ff @(posedge clock) begin
    if (tbl_we) prob_table[tbl_waddr] <= tbl_wdata;
  end

  // 8'hFF is "always wins" even though lfsr[7:0] can equal 8'hFF.
  assign win = (prob_q == 8'hFF) || (lfsr_q[7:0] < prob_q);

  always_comb begin
    state_d        = state_q;
    clr_idx_d      = clr_idx_q;
    arm_d          = arm_q;
    prob_d         = prob_q;
    reward_valid_d = reward_valid_q;
    reward_data_d  = reward_data_q;
    pull_count_d   = pull_count_q;
    lfsr_d         = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    case (state_q)
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {ACTION_WIDTH{1'b1}}) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.action_valid && action_ready_q) begin
          arm_d = bus.action_data;
          if (pull_count_q != 32'hFFFF_FFFF) pull_count_d = pull_count_q + 32'd1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        // Same-edge cfg write to this arm is not seen: read returns old data.
        prob_d  = prob_table[arm_q];
        state_d = S_DRAW;
      end
      S_DRAW: begin
        reward_data_d  = win ? REWARD_HIGH : REWARD_LOW;
        reward_valid_d = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (bus.reward_ready) begin
          reward_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    action_ready_d = (state_d == S_IDLE);
    cfg_ready_d    = (state_d != S_CLEAR);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_CLEAR;
      clr_idx_q      <= '0;
      arm_q          <= '0;
      prob_q         <= 8'd0;
      lfsr_q         <= LFSR_SEED;
      action_ready_q <= 1'b0;
      cfg_ready_q    <= 1'b0;
      reward_valid_q <= 1'b0;
      reward_data_q  <= '0;
      pull_count_q   <= 32'd0;
    end else begin
      state_q        <= state_d;
      clr_idx_q      <= clr_idx_d;
      arm_q          <= arm_d;
      prob_q         <= prob_d;
      lfsr_q         <= lfsr_d;
      action_ready_q <= action_ready_d;
      cfg_ready_q    <= cfg_ready_d;
      reward_valid_q <= reward_valid_d;
      reward_data_q  <= reward_data_d;
      pull_count_q   <= pull_count_d;
    end
  end

  assign bus.action_ready = action_ready_q;
  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.reward_valid = reward_valid_q;
  assign bus.reward_data  = reward_data_q;
  assign bus.pull_count   = pull_count_q;

endmodule
